// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus memory-mapped LED, switch, timer and
// 7-segment display registers, with a combinational read path for the CPU MEM stage.
module data_mem_responder #(
  parameter int RAM_WORDS = 128,
  parameter int SCAN_DIV  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  input  logic [7:0]  switches,
  output logic [7:0]  leds,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [15:0]         ram_q [RAM_WORDS];
  logic [7:0]          led_q, led_d;
  logic [7:0]          sw_meta_q, sw_sync_q;
  logic [15:0]         tcount_q, tcount_d;
  logic [15:0]         tcmp_q, tcmp_d;
  logic                flag_q, flag_d;
  logic [15:0]         disp_q, disp_d;
  logic [SCAN_DIV-1:0] scan_q, scan_d;
  logic [3:0]          an_q;
  logic [6:0]          seg_q;

  logic          ram_sel_s, io_sel_s, match_s, clr_s, unused_addr0_s;
  logic [AW-1:0] ram_idx_s;
  logic [2:0]    io_off_s;
  logic [1:0]    digit_s;
  logic [15:0]   rd_mux_s;

  // Active-low gfedcba hex decode.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
      default: hex7 = 7'b1111111;
    endcase
  endfunction

  // Byte address bit 0 never selects anything; registers live at 0xFF00..0xFF0A.
  assign unused_addr0_s = dmemaddr[0];
  assign ram_sel_s = (dmemaddr[15:AW+1] == '0);
  assign ram_idx_s = dmemaddr[AW:1];
  assign io_sel_s  = (dmemaddr[15:4] == 12'hFF0);
  assign io_off_s  = dmemaddr[3:1];
  assign match_s   = (tcount_q == tcmp_q) && (tcmp_q != 16'h0000);
  assign clr_s     = dmemwrite && io_sel_s && (io_off_s == 3'd4) && dmemwdata[0];

  always_comb begin
    rd_mux_s = 16'h0000;
    if (ram_sel_s) begin
      rd_mux_s = ram_q[ram_idx_s];
    end else if (io_sel_s) begin
      case (io_off_s)
        3'd0:    rd_mux_s = {8'h00, led_q};
        3'd1:    rd_mux_s = {8'h00, sw_sync_q};
        3'd2:    rd_mux_s = tcount_q;
        3'd3:    rd_mux_s = tcmp_q;
        3'd4:    rd_mux_s = {15'h0000, flag_q};
        3'd5:    rd_mux_s = disp_q;
        default: rd_mux_s = 16'h0000;
      endcase
    end else begin
      rd_mux_s = 16'h0000;
    end
  end

  assign dmemrdata = dmemread ? rd_mux_s : 16'h0000;

  always_comb begin
    led_d    = led_q;
    tcount_d = tcount_q + 16'd1;
    tcmp_d   = tcmp_q;
    disp_d   = disp_q;
    scan_d   = scan_q + SCAN_DIV'(1);
    if (dmemwrite && io_sel_s) begin
      case (io_off_s)
        3'd0:    led_d    = dmemwdata[7:0];
        3'd2:    tcount_d = dmemwdata;
        3'd3:    tcmp_d   = dmemwdata;
        3'd5:    disp_d   = dmemwdata;
        default: led_d    = led_q;
      endcase
    end else begin
      led_d = led_q;
    end
    // A same-cycle match beats a software clear so no event is lost.
    if (match_s) begin
      flag_d = 1'b1;
    end else if (clr_s) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
    digit_s = scan_d[SCAN_DIV-1 -: 2];
  end

  always_ff @(posedge clock) begin
    if (!reset && dmemwrite && ram_sel_s) begin
      ram_q[ram_idx_s] <= dmemwdata;
    end
  end

  // Display outputs are registered from next-state values so they track scan_q exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q     <= 8'h00;
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
      tcount_q  <= 16'h0000;
      tcmp_q    <= 16'h0000;
      flag_q    <= 1'b0;
      disp_q    <= 16'h0000;
      scan_q    <= '0;
      an_q      <= 4'b1110;
      seg_q     <= 7'b1000000;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      tcount_q  <= tcount_d;
      tcmp_q    <= tcmp_d;
      flag_q    <= flag_d;
      disp_q    <= disp_d;
      scan_q    <= scan_d;
      an_q      <= ~(4'b0001 << digit_s);
      seg_q     <= hex7(disp_d[{digit_s, 2'b00} +: 4]);
    end
  end

  assign leds = led_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule
